awgn_ctrl: RTL and testbench
============================

Name: awgn_ctrl

Overview:
- Sequencer for the boxmuller AWGN generator: seeds it, pulses init, discards warm-up outputs, then streams an exact number of noise samples.
- Serialises each x0/x1 pair into a single 16-bit valid/ready stream.
- Throttles the generator's ce so no sample is dropped under downstream backpressure.
- Sits between the channel model's noise adder and the generator instance.

Parameters:
- WARMUP_PAIRS, 16, number of initial gen_x_en pairs discarded after init.
- BURST_W, 16, width of burst_len and the internal sample counter.
- FIFO_DEPTH, 4, sample FIFO entries; power of two, minimum 2.
- SAMPLE_W, 16, sample width; must equal the generator output width.

Ports:
- clock  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to begin a burst.
- seed_in  in  64  seed; [31:0] goes to seed0, [63:32] goes to seed1.
- burst_len  in  BURST_W  number of samples to deliver.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last sample handshake.
- gen_init  out  1  generator init.
- gen_ce  out  1  generator clock enable.
- gen_seed0  out  32  registered seed to the generator.
- gen_seed1  out  32  registered seed to the generator.
- gen_x_en  in  1  generator pair valid.
- gen_x0  in  SAMPLE_W  generator sample.
- gen_x1  in  SAMPLE_W  generator sample.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_data  out  SAMPLE_W  stream sample.
- m_last  out  1  marks the final sample of the burst.

Behaviour:
- Reset values: busy=0, done=0, gen_init=0, gen_ce=0, gen_seed0=0, gen_seed1=0, m_valid=0, m_data=0, m_last=0. Reset also flushes the FIFO, clears all counters and forces IDLE. Reset mid-burst aborts with no done pulse.
- States: IDLE, SEED, WARM, RUN, DRAIN.
- IDLE:
  - start=1 and burst_len!=0: latch seeds and burst_len, busy=1, go to SEED.
  - start=1 and burst_len==0: done pulses the next cycle; busy stays 0.
  - start while busy is ignored.
- SEED: gen_init=1 and gen_ce=1 for exactly one cycle, then WARM.
- WARM: gen_ce=1. Count gen_x_en pulses; after the WARMUP_PAIRS-th pulse go to RUN. Warm-up samples never enter the FIFO.
- RUN:
  - gen_ce=1 only if free FIFO slots ≥ 2 and pairs requested < ceil(burst_len/2).
  - Free count is evaluated on registered occupancy plus the current-cycle pop.
  - gen_x_en is honoured only in a cycle with gen_ce=1; otherwise it is ignored.
  - Each accepted pair pushes x0 then x1 (two writes in one cycle).
  - On the final pair of an odd burst_len, only x0 is pushed.
  - Go to DRAIN when all burst_len samples have been pushed.
- DRAIN: gen_ce=0. When the FIFO is empty after the final handshake, pulse done=1 for one cycle, drop busy, return to IDLE.
- Stream rules:
  - m_valid = FIFO non-empty; m_data = FIFO head.
  - Pop when m_valid & m_ready.
  - m_data is stable while m_valid=1 and m_ready=0.
  - m_last=1 only on the burst_len-th delivered sample.
- Latency:
  - start to gen_init: 1 cycle.
  - Pair acceptance to m_valid: 1 cycle (registered FIFO).
- FIFO full with m_ready=0: gen_ce holds 0; the generator pipeline freezes and no sample is lost.
- Counters saturate at burst_len; no wrap is possible.

Optional Feature:
- Macro: AWGN_SCALE_EN.
- Defined: adds port scale_shift (in, 4 bits), latched at start. Each pushed sample is arithmetically right-shifted by scale_shift, sign preserved, before FIFO write; this sets the noise sigma.
- Undefined: port absent; samples pass unmodified.

Decomposition:
- Package awgn_pkg holds: the state enum (IDLE, SEED, WARM, RUN, DRAIN), SAMPLE_W, and the seed-split constants.
- Sub-module awgn_pair_fifo: synchronous FIFO with 0/1/2 writes and 1 read per cycle, and a free-count output.

Test Plan:
- seed 0x132C_6C00_132C_6C00, burst_len=8, m_ready=1 -> one gen_init pulse; 16 warm-up pairs discarded; 8 samples equal to pairs 17–20 in order x0,x1; m_last on the 8th; done one cycle after it.
- burst_len=5 -> exactly 5 samples; the 5th is x0 of pair 3; m_last on it; no further gen_ce.
- burst_len=32, m_ready toggling 1 cycle on / 3 off -> gen_ce never asserted with free<2; sample sequence identical to the m_ready=1 run.
- burst_len=0 start -> done pulses the next cycle; gen_init never asserts; busy stays 0.
- rst=1 for 1 cycle during RUN with 3 samples buffered -> the next cycle all outputs are at reset values; no done; a fresh start runs a full sequence.
- AWGN_SCALE_EN with scale_shift=2 and generator sample 0xFF00 -> m_data=0xFFC0.

Source files
------------

// File: rtl/awgn_pkg.sv
// Shared types and constants for the AWGN generator sequencer.
package awgn_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int SEED_W    = 32;
  localparam int SEED0_LSB = 0;
  localparam int SEED1_LSB = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEED  = 3'd1,
    WARM  = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4
  } state_t;

endpackage

// File: rtl/awgn_pair_fifo.sv
// Synchronous sample FIFO: up to two writes (wr0 then wr1) and one read per cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module awgn_pair_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   wr0_en,
  input  logic [W-1:0]           wr0_data,
  input  logic                   wr1_en,
  input  logic [W-1:0]           wr1_data,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] free
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          wr1_ok;
  logic          rd_ok;

  // wr1 is only meaningful alongside wr0 so the pair lands in order
  assign wr1_ok = wr0_en && wr1_en;
  assign rd_ok  = rd_en && !empty;

  always_ff @(posedge clock) begin
    if (wr0_en) mem[wr_ptr] <= wr0_data;
    if (wr1_ok) mem[wr_ptr + AW'(1)] <= wr1_data;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr0_en) + AW'(wr1_ok);
      rd_ptr <= rd_ptr + AW'(rd_ok);
      count  <= count + CW'(wr0_en) + CW'(wr1_ok) - CW'(rd_ok);
    end
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);
  assign free    = CW'(DEPTH) - count;

endmodule

// File: rtl/awgn_ctrl.sv
// Sequencer for the boxmuller AWGN generator: seed, init, warm-up discard, then an
// exact-length sample stream. Define AWGN_SCALE_EN to add the scale_shift sigma control.
//
// state | meaning
// IDLE  | waiting for start
// SEED  | one-cycle gen_init with seeds applied
// WARM  | discarding WARMUP_PAIRS generator pairs
// RUN   | accepting pairs into the FIFO while space and quota remain
// DRAIN | generator stopped, emptying the FIFO to the stream
module awgn_ctrl #(
  parameter int WARMUP_PAIRS = 16,
  parameter int BURST_W      = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int SAMPLE_W     = awgn_pkg::SAMPLE_W
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                start,
  input  logic [63:0]         seed_in,
  input  logic [BURST_W-1:0]  burst_len,
`ifdef AWGN_SCALE_EN
  input  logic [3:0]          scale_shift,
`endif
  output logic                busy,
  output logic                done,
  output logic                gen_init,
  output logic                gen_ce,
  output logic [31:0]         gen_seed0,
  output logic [31:0]         gen_seed1,
  input  logic                gen_x_en,
  input  logic [SAMPLE_W-1:0] gen_x0,
  input  logic [SAMPLE_W-1:0] gen_x1,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [SAMPLE_W-1:0] m_data,
  output logic                m_last
);

  import awgn_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = BURST_W + 1;
  localparam int WW = (WARMUP_PAIRS < 2) ? 1 : $clog2(WARMUP_PAIRS + 1);

  state_t state, state_nxt;

  logic [BURST_W-1:0]  len_q;
  logic [BURST_W-1:0]  pair_cnt;
  logic [BURST_W-1:0]  dlv_cnt;
  logic [WW-1:0]       warm_cnt;
  logic [PW-1:0]       pair_target;
  logic                last_pair;
  logic                pairs_left;
  logic [CW-1:0]       fifo_free;
  logic [CW-1:0]       free_eff;
  logic                fifo_empty;
  logic [SAMPLE_W-1:0] fifo_head;
  logic [SAMPLE_W-1:0] wr0_data;
  logic [SAMPLE_W-1:0] wr1_data;
  logic                ce_run;
  logic                accept;
  logic                push1;
  logic                pop;
  logic                done_nxt;
  logic                start_ok;

  assign start_ok    = (state == IDLE) && start && (burst_len != '0);
  assign pair_target = (PW'(len_q) + PW'(1)) >> 1;
  assign pairs_left  = PW'(pair_cnt) < pair_target;
  assign last_pair   = (PW'(pair_cnt) + PW'(1)) == pair_target;

  // A pop this cycle frees a slot in time for the pair landing on the same edge
  assign free_eff = fifo_free + CW'(pop);
  assign ce_run   = (free_eff >= CW'(2)) && pairs_left;

  // odd burst: the second sample of the final pair is dropped
  assign push1 = accept && !(last_pair && len_q[0]);

  assign pop     = m_valid && m_ready;
  assign m_valid = !fifo_empty;
  assign m_data  = m_valid ? fifo_head : '0;
  assign m_last  = m_valid && (dlv_cnt == len_q - BURST_W'(1));
  assign busy    = (state != IDLE);

`ifdef AWGN_SCALE_EN
  logic [3:0] shift_q;

  always_ff @(posedge clock) begin
    if (rst) shift_q <= '0;
    else if (start_ok) shift_q <= scale_shift;
  end

  assign wr0_data = SAMPLE_W'($signed(gen_x0) >>> shift_q);
  assign wr1_data = SAMPLE_W'($signed(gen_x1) >>> shift_q);
`else
  assign wr0_data = gen_x0;
  assign wr1_data = gen_x1;
`endif

  always_ff @(posedge clock) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gen_init  = 1'b0;
    gen_ce    = 1'b0;
    accept    = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (burst_len != '0) state_nxt = SEED;
          else done_nxt = 1'b1;
        end
      end
      SEED: begin
        gen_init  = 1'b1;
        gen_ce    = 1'b1;
        state_nxt = (WARMUP_PAIRS == 0) ? RUN : WARM;
      end
      WARM: begin
        gen_ce = 1'b1;
        if (gen_x_en && (warm_cnt == WW'(1))) state_nxt = RUN;
      end
      RUN: begin
        gen_ce = ce_run;
        accept = ce_run && gen_x_en;
        if (accept && last_pair) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pop && m_last) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      done      <= 1'b0;
      gen_seed0 <= '0;
      gen_seed1 <= '0;
      len_q     <= '0;
      pair_cnt  <= '0;
      dlv_cnt   <= '0;
      warm_cnt  <= '0;
    end else begin
      done <= done_nxt;
      if (start_ok) begin
        gen_seed0 <= seed_in[SEED0_LSB +: SEED_W];
        gen_seed1 <= seed_in[SEED1_LSB +: SEED_W];
        len_q     <= burst_len;
        pair_cnt  <= '0;
        dlv_cnt   <= '0;
        warm_cnt  <= WW'(WARMUP_PAIRS);
      end else begin
        if ((state == WARM) && gen_x_en) warm_cnt <= warm_cnt - WW'(1);
        if (accept) pair_cnt <= pair_cnt + BURST_W'(1);
        if (pop && (dlv_cnt != len_q)) dlv_cnt <= dlv_cnt + BURST_W'(1);
      end
    end
  end

  awgn_pair_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (SAMPLE_W)
  ) u_fifo (
    .clock    (clock),
    .rst      (rst),
    .wr0_en   (accept),
    .wr0_data (wr0_data),
    .wr1_en   (push1),
    .wr1_data (wr1_data),
    .rd_en    (pop),
    .rd_data  (fifo_head),
    .empty    (fifo_empty),
    .free     (fifo_free)
  );

endmodule

// File: tb/tb_awgn_ctrl.sv
// Scoreboard bench for awgn_ctrl with a behavioural generator model.
module tb_awgn_ctrl;

  typedef struct {
    logic [15:0] d;
    logic        l;
  } exp_t;

  logic        clock = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] seed_in;
  logic [15:0] burst_len;
  logic        busy, done, gen_init, gen_ce;
  logic [31:0] gen_seed0, gen_seed1;
  logic        gen_x_en;
  logic [15:0] gen_x0, gen_x1;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic        m_last;
`ifdef AWGN_SCALE_EN
  logic [3:0]  scale_shift = 4'd0;
`endif

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  int   cyc = 0;
  logic [7:0] gp = 8'd0;
  int   cur_len = 0;
  int   tb_pushed = 0;
  int   tb_popped = 0;
  int   n_init = 0;
  logic exp_done = 1'b0;
  int   ready_mode = 0;
  logic ready_man = 1'b0;
  logic force_data = 1'b0;

  always #5 clock = ~clock;

  awgn_ctrl dut (
    .clock     (clock),
    .rst       (rst),
    .start     (start),
    .seed_in   (seed_in),
    .burst_len (burst_len),
`ifdef AWGN_SCALE_EN
    .scale_shift (scale_shift),
`endif
    .busy      (busy),
    .done      (done),
    .gen_init  (gen_init),
    .gen_ce    (gen_ce),
    .gen_seed0 (gen_seed0),
    .gen_seed1 (gen_seed1),
    .gen_x_en  (gen_x_en),
    .gen_x0    (gen_x0),
    .gen_x1    (gen_x1),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  // Generator model: pair n (1-based since init) carries x0=A0nn, x1=B0nn.
  // It stalls every third cycle and waves garbage on x_en while ce is low.
  always_comb begin
    gen_x_en = 1'b0;
    gen_x0   = 16'hDEAD;
    gen_x1   = 16'hBEEF;
    if (gen_ce) begin
      gen_x_en = !gen_init && ((cyc % 3) != 2);
      gen_x0   = force_data ? 16'hFF00 : {8'hA0, gp + 8'd1};
      gen_x1   = force_data ? 16'hFF00 : {8'hB0, gp + 8'd1};
    end else begin
      gen_x_en = cyc[0];
    end
  end

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (gen_init) gp <= 8'd0;
    else if (gen_ce && gen_x_en) begin
      gp <= gp + 8'd1;
      if (gp >= 8'd16) begin
        if ((int'(gp) - 15) == (cur_len + 1) / 2 && (cur_len % 2) == 1) tb_pushed = tb_pushed + 1;
        else tb_pushed = tb_pushed + 2;
      end
    end
  end

  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0: m_ready = 1'b1;
      1: m_ready = ((cyc % 4) == 0);
      default: m_ready = ready_man;
    endcase
  end

  // Monitor: done timing, stream scoreboard and generator-throttle rules
  always @(negedge clock) begin
    logic en;
    exp_t e;
    int occ, fe;
    en = 1'b0;
    if (gen_init) n_init = n_init + 1;
    if (done || exp_done) begin
      checks = checks + 1;
      if (done !== exp_done) begin
        failures = failures + 1;
        $display("FAIL done_pulse: got %b expected %b", done, exp_done);
      end
    end
    if (!rst && start && !busy && burst_len == 16'd0) en = 1'b1;
    if (!rst && gen_ce && busy && !gen_init && gp >= 8'd16) begin
      occ = tb_pushed - tb_popped;
      fe  = 4 - occ + ((m_valid && m_ready) ? 1 : 0);
      checks = checks + 1;
      if (fe < 2 || (int'(gp) - 16) >= (cur_len + 1) / 2) begin
        failures = failures + 1;
        $display("FAIL gen_ce_throttle: got ce=1 free=%0d pairs=%0d required free>=2 pairs<%0d",
                 fe, int'(gp) - 16, (cur_len + 1) / 2);
      end
    end
    if (!rst && m_valid && m_ready) begin
      tb_popped = tb_popped + 1;
      checks = checks + 1;
      if (q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL stream_extra: got sample %h expected none", m_data);
      end else begin
        e = q.pop_front();
        if (m_data !== e.d || m_last !== e.l) begin
          failures = failures + 1;
          $display("FAIL stream_sample: got %h last=%b expected %h last=%b", m_data, m_last, e.d, e.l);
        end
        if (e.l) en = 1'b1;
      end
    end
    exp_done = en;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks = checks + 1;
    if (act !== req) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_burst(input int len);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      e.d = {((i % 2) == 1) ? 8'hB0 : 8'hA0, 8'(17 + i / 2)};
      e.l = (i == len - 1);
      q.push_back(e);
    end
  endtask

  task automatic check_reset_outs(input string name);
    @(negedge clock);
    check(name, {busy, done, gen_init, gen_ce, gen_seed0, gen_seed1, m_valid, m_data, m_last}, '0);
  endtask

  task automatic issue_start(input int len, input logic [63:0] seed);
    @(posedge clock); #1;
    start = 1'b1;
    seed_in = seed;
    burst_len = 16'(len);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic run_burst(input string name, input int len, input logic [63:0] seed, input int mode);
    int k;
    ready_mode = mode;
    cur_len = len;
    tb_pushed = 0;
    tb_popped = 0;
    issue_start(len, seed);
    @(negedge clock);
    check({name, "_init_lat"}, {gen_init, busy}, 2'b11);
    @(negedge clock);
    check({name, "_seeds"}, {gen_seed1, gen_seed0}, seed);
    // a start while busy must not disturb the burst
    @(posedge clock); #1;
    start = 1'b1;
    burst_len = 16'd3;
    @(posedge clock); #1;
    start = 1'b0;
    k = 0;
    while (busy && k < 3000) begin
      @(negedge clock);
      k++;
    end
    check({name, "_finish"}, busy, 1'b0);
    repeat (2) @(negedge clock);
    check({name, "_queue_empty"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int k;
    int n0;
    rst = 1'b1;
    start = 1'b0;
    seed_in = '0;
    burst_len = '0;
    repeat (3) @(posedge clock);
    #1 rst = 1'b0;
    check_reset_outs("reset_state");

    n0 = n_init;
    push_burst(8);
    run_burst("b8", 8, 64'h132C_6C00_132C_6C00, 0);
    check("b8_one_init", 32'(n_init - n0), 32'd1);

    push_burst(5);
    run_burst("b5", 5, 64'h1111_2222_3333_4444, 0);
    repeat (4) begin
      @(negedge clock);
      check("b5_ce_idle", gen_ce, 1'b0);
    end

    push_burst(32);
    run_burst("b32", 32, 64'h0BAD_F00D_CAFE_0001, 1);

    n0 = n_init;
    ready_mode = 0;
    @(posedge clock); #1;
    start = 1'b1;
    burst_len = 16'd0;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("zero_busy", busy, 1'b0);
    end
    check("zero_no_init", 32'(n_init - n0), 32'd0);

    // abort mid-run with three samples buffered
    ready_man = 1'b0;
    push_burst(8);
    cur_len = 8;
    tb_pushed = 0;
    tb_popped = 0;
    ready_mode = 2;
    issue_start(8, 64'h0000_0001_0000_0002);
    k = 0;
    while (!m_valid && k < 500) begin
      @(negedge clock);
      k++;
    end
    check("abort_fill", m_valid, 1'b1);
    repeat (4) @(negedge clock);
    check("abort_full_ce", gen_ce, 1'b0);
    check("abort_head", m_data, 16'hA011);
    ready_man = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ready_man = 1'b0;
    repeat (2) @(negedge clock);
    check("abort_still_busy", {busy, m_valid}, 2'b11);
    @(posedge clock); #1;
    rst = 1'b1;
    q.delete();
    tb_pushed = 0;
    tb_popped = 0;
    @(posedge clock); #1;
    rst = 1'b0;
    check_reset_outs("abort_reset_outs");
    repeat (4) @(negedge clock);
    check("abort_idle", {busy, m_valid}, 2'b00);

    push_burst(8);
    run_burst("fresh", 8, 64'h132C_6C00_132C_6C00, 0);

`ifdef AWGN_SCALE_EN
    begin
      exp_t e;
      force_data = 1'b1;
      scale_shift = 4'd2;
      e.d = 16'hFFC0; e.l = 1'b0; q.push_back(e);
      e.d = 16'hFFC0; e.l = 1'b1; q.push_back(e);
      run_burst("scale", 2, 64'h5, 0);
      force_data = 1'b0;
      scale_shift = 4'd0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
